ram_arb: RTL and testbench

// - Parametrised synchronous RAM for the subleq machine, shared by NCH requesters
//   (e.g. ch0 = instruction fetch, ch1 = operand read/write) through a round-robin arbiter.
// - Replaces the asynchronous, ctl-edge-written 8x256 store with a clocked single port.
// - Handshake: one access per cycle, registered read data and a per-channel read-valid.

---
 rtl/ram_arb.sv | 146 ++++++++++++++
 tb/tb_ram_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// Clocked single-port RAM shared by NCH requesters through a round-robin arbiter.
// Optional power-up clear sweep enabled by defining RAM_ARB_CLR_EN.
module ram_arb #(
  parameter int    DW        = 8,
  parameter int    AW        = 8,
  parameter int    NCH       = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_adr,
  input  logic [NCH*DW-1:0] ch_wdat,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_rvld,
  output logic [DW-1:0]     rdat,
  output logic              busy
);

  localparam int DEPTH = 1 << AW;
  localparam int RW    = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DW-1:0]  mem [DEPTH];

  logic [RW-1:0]  rr_q, rr_d;
  logic [NCH-1:0] rvld_q, rvld_d;
  logic [DW-1:0]  rdat_q, rdat_d;

  logic [RW-1:0]  sel, jj;
  logic [NCH-1:0] gnt;
  logic           any;
  logic           open;
  logic           sweep;
  logic [AW-1:0]  clr_adr;

  logic [AW-1:0]  adr_sel;
  logic [DW-1:0]  wdat_sel;
  logic           we_sel;

  logic           mem_we;
  logic [AW-1:0]  mem_wa;
  logic [DW-1:0]  mem_wd;

`ifdef RAM_ARB_CLR_EN
  typedef enum logic {CLR, RUN} st_e;

  st_e           st_q;
  logic [AW-1:0] clr_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= CLR;
      clr_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      unique case (st_q)
        CLR: begin
          clr_q <= clr_q + AW'(1);
          if (clr_q == AW'(DEPTH - 1)) begin
            st_q   <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: st_q <= RUN;
        default: st_q <= RUN;
      endcase
    end
  end

  assign busy    = busy_q;
  assign open    = !busy_q && !rst;
  assign sweep   = (st_q == CLR) && !rst;
  assign clr_adr = clr_q;
`else
  assign busy    = 1'b0;
  assign open    = !rst;
  assign sweep   = 1'b0;
  assign clr_adr = '0;
`endif

  // Scan upward from the channel after the last winner, wrapping once.
  always_comb begin
    gnt = '0;
    sel = '0;
    any = 1'b0;
    jj  = '0;
    for (int k = 1; k <= NCH; k++) begin
      jj = RW'((int'(rr_q) + k) % NCH);
      if (open && !any && ch_req[jj]) begin
        gnt[jj] = 1'b1;
        sel     = jj;
        any     = 1'b1;
      end
    end
  end

  assign ch_gnt   = gnt;
  assign adr_sel  = ch_adr[sel*AW +: AW];
  assign wdat_sel = ch_wdat[sel*DW +: DW];
  assign we_sel   = ch_we[sel];

  always_comb begin
    rr_d   = rr_q;
    rvld_d = '0;
    rdat_d = rdat_q;
    mem_we = 1'b0;
    mem_wa = adr_sel;
    mem_wd = wdat_sel;
    if (any) begin
      rr_d = sel;
      if (we_sel) begin
        mem_we = 1'b1;
      end else begin
        rvld_d[sel] = 1'b1;
        rdat_d      = mem[adr_sel];
      end
    end
    if (sweep) begin
      mem_we = 1'b1;
      mem_wa = clr_adr;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= RW'(NCH - 1);
      rvld_q <= '0;
      rdat_q <= '0;
    end else begin
      rr_q   <= rr_d;
      rvld_q <= rvld_d;
      rdat_q <= rdat_d;
    end
  end

  assign ch_rvld = rvld_q;
  assign rdat    = rdat_q;

endmodule

// File: tb/tb_ram_arb.sv
// Randomised and directed bench for ram_arb (NCH=3, AW=4, DW=8)
// against a word-array reference model.
module tb_ram_arb;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int NCH = 3;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    ch_req = '0;
  logic [NCH-1:0]    ch_we = '0;
  logic [NCH*AW-1:0] ch_adr = '0;
  logic [NCH*DW-1:0] ch_wdat = '0;
  logic [NCH-1:0]    ch_gnt;
  logic [NCH-1:0]    ch_rvld;
  logic [DW-1:0]     rdat;
  logic              busy;

  ram_arb #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_we(ch_we),
    .ch_adr(ch_adr), .ch_wdat(ch_wdat), .ch_gnt(ch_gnt),
    .ch_rvld(ch_rvld), .rdat(rdat), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic          m_known [DEPTH];
  int            m_rr;
  logic [DW-1:0] m_rdat;
  logic          m_rdat_ok;
  logic [NCH-1:0] m_rvld;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic int ref_gnt(input logic [NCH-1:0] r);
    for (int j = m_rr + 1; j < NCH; j++) if (r[j]) return j;
    for (int j = 0; j <= m_rr; j++) if (r[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    m_rr      = NCH - 1;
    m_rdat    = '0;
    m_rdat_ok = 1'b1;
    m_rvld    = '0;
  endtask

  task automatic step(input logic [NCH-1:0] req, input logic [NCH-1:0] we,
                      input logic [NCH*AW-1:0] adr,
                      input logic [NCH*DW-1:0] wd);
    int g;
    logic [AW-1:0] a;
    @(negedge clk);
    ch_req = req; ch_we = we; ch_adr = adr; ch_wdat = wd;
    #1;
    g = ref_gnt(req);
    check("gnt", 32'(ch_gnt), (g < 0) ? 32'd0 : 32'(1 << g));
    @(posedge clk);
    m_rvld = '0;
    if (g >= 0) begin
      m_rr = g;
      a = adr[g*AW +: AW];
      if (we[g]) begin
        m_mem[a]   = wd[g*DW +: DW];
        m_known[a] = 1'b1;
      end else begin
        m_rvld[g]  = 1'b1;
        m_rdat     = m_mem[a];
        m_rdat_ok  = m_known[a];
      end
    end
    #1;
    check("rvld", 32'(ch_rvld), 32'(m_rvld));
    if (m_rdat_ok) check("rdat", 32'(rdat), 32'(m_rdat));
  endtask

`ifdef RAM_ARB_CLR_EN
  task automatic sweep_wait();
    int n;
    n = 0;
    ch_req = 3'b001; ch_we = '0; ch_adr = '0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
      check("gnt_busy", 32'(ch_gnt), 32'd0);
    end
    ch_req = '0;
    check("busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b1;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    model_reset();
    #12;
    check("rst_rvld", 32'(ch_rvld), 32'd0);
    check("rst_rdat", 32'(rdat), 32'd0);
`ifdef RAM_ARB_CLR_EN
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
`ifdef RAM_ARB_CLR_EN
    sweep_wait();
    for (int i = 0; i < DEPTH; i++)
      step(3'b001, 3'b000, 12'(i), '0);
`endif

    step(3'b001, 3'b001, 12'h005, 24'h000003);
    step(3'b001, 3'b000, 12'h005, '0);
    check("single_rdat", 32'(rdat), 32'h03);

    step(3'b001, 3'b001, 12'h00a, 24'h0000a5);
    step(3'b001, 3'b000, 12'h00a, '0);
    check("raw_rdat", 32'(rdat), 32'ha5);
    check("raw_rvld", 32'(ch_rvld), 32'h1);

    for (int i = 0; i < 6; i++)
      step(3'b011, 3'b000, 12'h0a5, '0);

    step(3'b100, 3'b000, 12'h500, '0);
    check("wrap_ch2", 32'(ch_rvld), 32'h4);
    step(3'b011, 3'b000, 12'h0a5, '0);
    check("wrap_ch0", 32'(ch_rvld), 32'h1);
    step(3'b011, 3'b000, 12'h0a5, '0);
    check("wrap_ch1", 32'(ch_rvld), 32'h2);

    step(3'b000, 3'b000, '0, '0);

    for (int i = 0; i < 200; i++)
      step(NCH'($urandom_range(0, 7)), NCH'($urandom),
           12'($urandom), 24'($urandom));

    step(3'b010, 3'b000, 12'h050, '0);
    check("pre_rst_rvld", 32'(ch_rvld), 32'h2);
    #1 rst = 1'b1;
    ch_req = '0;
    #1;
    model_reset();
    check("midrst_rvld", 32'(ch_rvld), 32'd0);
    check("midrst_rdat", 32'(rdat), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef RAM_ARB_CLR_EN
    sweep_wait();
`endif
    step(3'b011, 3'b000, 12'h055, '0);
    check("post_rst_ch0", 32'(ch_rvld), 32'h1);
    step(3'b011, 3'b000, 12'h055, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
